// File: rtl/gbuf_arb_pkg.sv
// Shared definitions for the global-buffer port arbiter: CPU response state
// encoding, read-owner codes and default parameter values.
package gbuf_arb_pkg;

  // CPU response state machine encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Which requester owns the BRAM read data arriving next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_TPU  = 2'd2
  } owner_e;

  localparam int DEFAULT_ADDR_BITS = 12;
  localparam int DEFAULT_DATA_BITS = 32;
  localparam int DEFAULT_MAX_WAIT  = 8;

endpackage

// File: rtl/gbuf_port_arbiter_if.sv
// Bundle of the CPU request/response, TPU request/response and BRAM port
// signals around one global buffer. The arbiter uses the slave view; the
// requesters and the BRAM together form the master view.
interface gbuf_port_arbiter_if #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 32
);

  // CPU (CFU command path)
  logic                 cpu_req_valid;
  logic                 cpu_req_ready;
  logic                 cpu_req_wr;
  logic [31:0]          cpu_req_addr;
  logic [DATA_BITS-1:0] cpu_req_wdata;
  logic                 cpu_rsp_valid;
  logic                 cpu_rsp_ready;
  logic [DATA_BITS-1:0] cpu_rsp_rdata;

  // TPU engine
  logic                 tpu_req_valid;
  logic                 tpu_req_ready;
  logic                 tpu_req_wr;
  logic [ADDR_BITS-1:0] tpu_req_addr;
  logic [DATA_BITS-1:0] tpu_req_wdata;
  logic                 tpu_rsp_valid;
  logic [DATA_BITS-1:0] tpu_rsp_rdata;

  // Single-port BRAM
  logic                 ram_wr_en;
  logic [ADDR_BITS-1:0] ram_index;
  logic [DATA_BITS-1:0] ram_data_in;
  logic [DATA_BITS-1:0] ram_data_out;

  modport slave (
    input  cpu_req_valid, cpu_req_wr, cpu_req_addr, cpu_req_wdata, cpu_rsp_ready,
    output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata,
    input  tpu_req_valid, tpu_req_wr, tpu_req_addr, tpu_req_wdata,
    output tpu_req_ready, tpu_rsp_valid, tpu_rsp_rdata,
    output ram_wr_en, ram_index, ram_data_in,
    input  ram_data_out
  );

  modport master (
    output cpu_req_valid, cpu_req_wr, cpu_req_addr, cpu_req_wdata, cpu_rsp_ready,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata,
    output tpu_req_valid, tpu_req_wr, tpu_req_addr, tpu_req_wdata,
    input  tpu_req_ready, tpu_rsp_valid, tpu_rsp_rdata,
    input  ram_wr_en, ram_index, ram_data_in,
    output ram_data_out
  );

endinterface

// File: rtl/gbuf_rsp_hold.sv
// CPU read-response register. Presents BRAM data straight through in the
// cycle after the grant (WAIT), captures it, and keeps presenting the captured
// word (HOLD) until the CPU accepts it, so later TPU reads cannot disturb it.
module gbuf_rsp_hold
  import gbuf_arb_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [DATA_BITS-1:0] ram_rdata_i,
  input  logic                 rsp_ready_i,
  output logic                 rsp_valid_o,
  output logic [DATA_BITS-1:0] rsp_rdata_o,
  output logic [1:0]           state_o
);

  logic [1:0]           state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;

  // Next-state and capture logic for the response handshake.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_WAIT;
      ST_WAIT: begin
        hold_d  = ram_rdata_i;
        state_d = rsp_ready_i ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: if (rsp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and hold register update; reset drops any pending response.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same edge regardless of statement order.
    if (reset) begin
      state_q <= ST_IDLE;
      // NOTE: the hold word is a single register feeding an output, so it is
      // reset to give a defined zero on cpu_rsp_rdata after reset.
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign rsp_valid_o = (state_q == ST_WAIT) || (state_q == ST_HOLD);
  assign rsp_rdata_o = (state_q == ST_WAIT) ? ram_rdata_i : hold_q;
  assign state_o     = state_q;

endmodule

// File: rtl/gbuf_port_arbiter.sv
// Arbiter in front of one single-port global buffer BRAM shared by the CPU and
// the TPU. The TPU wins every conflict; the CPU may have one read in flight.
// Optional feature macro: GBUF_ARB_STARVE_GUARD_EN -- when defined, a CPU
// request blocked by the TPU for MAX_WAIT cycles is forced through.
module gbuf_port_arbiter
  import gbuf_arb_pkg::*;
#(
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int MAX_WAIT  = DEFAULT_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  gbuf_port_arbiter_if.slave bus
);

  logic                 cpu_idle;
  logic                 force_cpu;
  logic                 tpu_ready;
  logic                 cpu_ready;
  logic                 tpu_grant;
  logic                 cpu_grant;
  logic [1:0]           cpu_state;
  logic                 cpu_rsp_valid;
  logic [DATA_BITS-1:0] cpu_rsp_rdata;

  logic [ADDR_BITS-1:0] index_q, index_d;
  owner_e               owner_q, owner_d;
  logic                 wr_en;
  logic [DATA_BITS-1:0] data_in;

  // Address bits above the BRAM index width are deliberately ignored (wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.cpu_req_addr[31:ADDR_BITS];

  assign cpu_idle = (cpu_state == ST_IDLE);

`ifdef GBUF_ARB_STARVE_GUARD_EN
  localparam int                CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Count cycles the CPU is ready to go but blocked by a TPU request.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (cpu_grant) begin
      wait_cnt_d = '0;
    end else if (bus.cpu_req_valid && cpu_idle && bus.tpu_req_valid &&
                 (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (reset) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end

  assign force_cpu = bus.cpu_req_valid && cpu_idle && (wait_cnt_q == CNT_MAX);
`else
  localparam int unused_max_wait = MAX_WAIT;
  assign force_cpu = 1'b0;
`endif

  // Grants: nothing is accepted while reset is asserted.
  assign tpu_ready = !reset && !force_cpu;
  assign cpu_ready = !reset && bus.cpu_req_valid && cpu_idle &&
                     (!bus.tpu_req_valid || force_cpu);
  assign tpu_grant = bus.tpu_req_valid && tpu_ready;
  assign cpu_grant = cpu_ready;

  // BRAM port mux; the index holds its last value when nobody is granted.
  always_comb begin
    wr_en   = 1'b0;
    index_d = index_q;
    data_in = '0;
    owner_d = OWN_NONE;
    if (tpu_grant) begin
      wr_en   = bus.tpu_req_wr;
      index_d = bus.tpu_req_addr;
      data_in = bus.tpu_req_wdata;
      owner_d = bus.tpu_req_wr ? OWN_NONE : OWN_TPU;
    end else if (cpu_grant) begin
      wr_en   = bus.cpu_req_wr;
      index_d = bus.cpu_req_addr[ADDR_BITS-1:0];
      data_in = bus.cpu_req_wdata;
      owner_d = bus.cpu_req_wr ? OWN_NONE : OWN_CPU;
    end
  end

  // Remember the last index driven and who owns next cycle's read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      index_q <= '0;
      owner_q <= OWN_NONE;
    end else begin
      index_q <= index_d;
      owner_q <= owner_d;
    end
  end

  gbuf_rsp_hold #(
    .DATA_BITS (DATA_BITS)
  ) u_rsp_hold (
    .clk         (clk),
    .reset       (reset),
    .start_i     (cpu_grant && !bus.cpu_req_wr),
    .ram_rdata_i (bus.ram_data_out),
    .rsp_ready_i (bus.cpu_rsp_ready),
    .rsp_valid_o (cpu_rsp_valid),
    .rsp_rdata_o (cpu_rsp_rdata),
    .state_o     (cpu_state)
  );

  assign bus.cpu_req_ready = cpu_ready;
  assign bus.cpu_rsp_valid = cpu_rsp_valid;
  assign bus.cpu_rsp_rdata = cpu_rsp_rdata;

  assign bus.tpu_req_ready = tpu_ready;
  assign bus.tpu_rsp_valid = (owner_q == OWN_TPU);
  assign bus.tpu_rsp_rdata = (owner_q == OWN_TPU) ? bus.ram_data_out : '0;

  assign bus.ram_wr_en   = wr_en;
  assign bus.ram_index   = index_d;
  assign bus.ram_data_in = data_in;

endmodule
